// File: rtl/control_pipe_unit_if.sv
// Decode-to-execute control channel: instruction handshake in, stall/flush
// controls in, registered execute control bundle out.
interface control_pipe_unit_if #(
    parameter int INSTR_W    = 32,
    parameter int ALU_CTRL_W = 4
);
    logic [INSTR_W-1:0]    instr_d;
    logic                  valid_d;
    logic                  ready_d;
    logic                  stall_e;
    logic                  flush;
    logic                  valid_e;
    logic                  reg_write_e;
    logic                  mem_to_reg_e;
    logic                  mem_write_e;
    logic                  alu_src_e;
    logic                  reg_dst_e;
    logic                  branch_e;
    logic                  jump_e;
    logic [1:0]            alu_op_e;
    logic [ALU_CTRL_W-1:0] alu_control_e;
    logic                  mul_e;
    logic                  illegal_e;

    modport master (
        output instr_d, valid_d, stall_e, flush,
        input  ready_d, valid_e, reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e,
               reg_dst_e, branch_e, jump_e, alu_op_e, alu_control_e, mul_e, illegal_e
    );

    modport slave (
        input  instr_d, valid_d, stall_e, flush,
        output ready_d, valid_e, reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e,
               reg_dst_e, branch_e, jump_e, alu_op_e, alu_control_e, mul_e, illegal_e
    );
endinterface

// File: rtl/control_pipe_unit.sv
// Registered MIPS-subset main decoder on the decode/execute boundary, with
// bubble insertion for stall, flush and the multi-cycle multiply interlock.
module control_pipe_unit #(
    parameter int INSTR_W     = 32,
    parameter int ALU_CTRL_W  = 4,
    parameter int MUL_LATENCY = 3
) (
    input logic                clk,
    input logic                rst_n,
    control_pipe_unit_if.slave bus
);
    localparam int CNT_W = $clog2(MUL_LATENCY + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_MUL = 6'b011000;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(4'b0000);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(4'b0001);
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(4'b0010);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(4'b0110);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(4'b0111);
    localparam logic [ALU_CTRL_W-1:0] ALU_MUL = ALU_CTRL_W'(4'b1111);

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic                  alu_src;
        logic                  reg_dst;
        logic                  branch;
        logic                  jump;
        logic [1:0]            alu_op;
        logic [ALU_CTRL_W-1:0] alu_control;
        logic                  mul;
        logic                  illegal;
    } bundle_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    bundle_t          ex_q, ex_d;
    bundle_t          dec;
    logic             illegal;
    logic             accept;
    logic [5:0]       opcode, funct;
    logic             unused_instr;

    assign opcode       = bus.instr_d[31:26];
    assign funct        = bus.instr_d[5:0];
    assign unused_instr = ^bus.instr_d;

    always_comb begin
        dec       = '0;
        illegal   = 1'b0;
        dec.valid = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                dec.reg_write = 1'b1;
                dec.reg_dst   = 1'b1;
                dec.alu_op    = 2'd2;
                case (funct)
                    F_ADD:   dec.alu_control = ALU_ADD;
                    F_SUB:   dec.alu_control = ALU_SUB;
                    F_AND:   dec.alu_control = ALU_AND;
                    F_OR:    dec.alu_control = ALU_OR;
                    F_SLT:   dec.alu_control = ALU_SLT;
                    F_MUL: begin
                        dec.alu_control = ALU_MUL;
                        dec.mul         = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                dec.reg_write   = 1'b1;
                dec.mem_to_reg  = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_ADD;
            end
            OP_SW: begin
                dec.mem_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_ADD;
            end
            OP_ADDI: begin
                dec.reg_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_ADD;
            end
            OP_BEQ: begin
                dec.branch      = 1'b1;
                dec.alu_op      = 2'd1;
                dec.alu_control = ALU_SUB;
            end
            OP_J: begin
                dec.jump   = 1'b1;
                dec.alu_op = 2'd3;
            end
            default: illegal = 1'b1;
        endcase
        // Unsupported encodings still travel down the pipe so execute can trap.
        if (illegal) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
        end
    end

    assign bus.ready_d = rst_n & ~bus.stall_e & ~bus.flush & (state_q == IDLE);
    assign accept      = bus.valid_d & bus.ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ex_d    = ex_q;
        if (bus.flush) begin
            ex_d    = '0;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (!bus.stall_e) begin
            if (accept) begin
                ex_d = dec;
                if (dec.mul && (MUL_LATENCY > 1)) begin
                    state_d = MUL_BUSY;
                    cnt_d   = CNT_W'(MUL_LATENCY - 1);
                end
            end else begin
                ex_d = '0;
                if (state_q == MUL_BUSY) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
        end
    end

    assign bus.valid_e       = ex_q.valid;
    assign bus.reg_write_e   = ex_q.reg_write;
    assign bus.mem_to_reg_e  = ex_q.mem_to_reg;
    assign bus.mem_write_e   = ex_q.mem_write;
    assign bus.alu_src_e     = ex_q.alu_src;
    assign bus.reg_dst_e     = ex_q.reg_dst;
    assign bus.branch_e      = ex_q.branch;
    assign bus.jump_e        = ex_q.jump;
    assign bus.alu_op_e      = ex_q.alu_op;
    assign bus.alu_control_e = ex_q.alu_control;
    assign bus.mul_e         = ex_q.mul;
    assign bus.illegal_e     = ex_q.illegal;
endmodule

// File: tb/tb_control_pipe_unit.sv
// Directed bench for control_pipe_unit: decode table, stall/flush priority,
// multiply interlock timing and reset behaviour with MUL_LATENCY=3.
module tb_control_pipe_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    control_pipe_unit_if #(.INSTR_W(32), .ALU_CTRL_W(4)) bus ();

    control_pipe_unit #(.INSTR_W(32), .ALU_CTRL_W(4), .MUL_LATENCY(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Bundle packing: {valid, rw, m2r, mw, asrc, rdst, br, j, op[1:0], ac[3:0], mul, ill}
    function automatic logic [15:0] bnd(logic v, logic rw, logic mr, logic mw, logic as,
                                        logic rd, logic br, logic j, logic [1:0] op,
                                        logic [3:0] ac, logic m, logic il);
        return {v, rw, mr, mw, as, rd, br, j, op, ac, m, il};
    endfunction

    function automatic logic [15:0] obs();
        return {bus.valid_e, bus.reg_write_e, bus.mem_to_reg_e, bus.mem_write_e, bus.alu_src_e,
                bus.reg_dst_e, bus.branch_e, bus.jump_e, bus.alu_op_e, bus.alu_control_e,
                bus.mul_e, bus.illegal_e};
    endfunction

    function automatic logic [31:0] rt(logic [5:0] f);
        return {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, f};
    endfunction

    function automatic logic [31:0] it(logic [5:0] op);
        return {op, 5'd4, 5'd5, 16'h0010};
    endfunction

    task automatic chk(input string tag, input logic [15:0 ] o, input logic [15:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%04h expected=%04h", tag, o, e);
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic st, input logic fl);
        bus.valid_d = v;
        bus.instr_d = ins;
        bus.stall_e = st;
        bus.flush   = fl;
        #1;
    endtask

    localparam logic [15:0] B_NONE = 16'h0000;
    localparam logic [15:0] B_ILL  = 16'h8001;

    logic [31:0] s_ins [9];
    logic [15:0] s_exp [9];
    logic [15:0] b_lw, b_add, b_sub, b_sw, b_mul;

    initial begin
        b_lw  = bnd(1,1,1,0,1,0,0,0,2'd0,4'b0010,0,0);
        b_add = bnd(1,1,0,0,0,1,0,0,2'd2,4'b0010,0,0);
        b_sub = bnd(1,1,0,0,0,1,0,0,2'd2,4'b0110,0,0);
        b_sw  = bnd(1,0,0,1,1,0,0,0,2'd0,4'b0010,0,0);
        b_mul = bnd(1,1,0,0,0,1,0,0,2'd2,4'b1111,1,0);

        s_ins[0] = rt(6'b100000); s_exp[0] = b_add;
        s_ins[1] = rt(6'b100010); s_exp[1] = b_sub;
        s_ins[2] = rt(6'b100100); s_exp[2] = bnd(1,1,0,0,0,1,0,0,2'd2,4'b0000,0,0);
        s_ins[3] = rt(6'b100101); s_exp[3] = bnd(1,1,0,0,0,1,0,0,2'd2,4'b0001,0,0);
        s_ins[4] = rt(6'b101010); s_exp[4] = bnd(1,1,0,0,0,1,0,0,2'd2,4'b0111,0,0);
        s_ins[5] = it(6'b000100); s_exp[5] = bnd(1,0,0,0,0,0,1,0,2'd1,4'b0110,0,0);
        s_ins[6] = it(6'b000010); s_exp[6] = bnd(1,0,0,0,0,0,0,1,2'd3,4'b0000,0,0);
        s_ins[7] = it(6'b001000); s_exp[7] = bnd(1,1,0,0,1,0,0,0,2'd0,4'b0010,0,0);
        s_ins[8] = it(6'b101011); s_exp[8] = b_sw;

        // Reset held with a valid lw presented
        rst_n = 1'b0;
        drive(1, it(6'b100011), 0, 0);
        edge_wait();
        edge_wait();
        chk("reset_bundle", obs(), B_NONE);
        chk("reset_ready", {15'd0, bus.ready_d}, 16'd0);
        rst_n = 1'b1;
        #1;
        chk("post_reset_ready", {15'd0, bus.ready_d}, 16'd1);
        edge_wait();
        chk("lw_bundle", obs(), b_lw);

        // Back-to-back stream
        for (int i = 0; i < 9; i++) begin
            drive(1, s_ins[i], 0, 0);
            chk($sformatf("stream_ready_%0d", i), {15'd0, bus.ready_d}, 16'd1);
            edge_wait();
            chk($sformatf("stream_bundle_%0d", i), obs(), s_exp[i]);
        end

        // Stall 3 cycles with sw in execute
        drive(1, rt(6'b100000), 1, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall_ready_%0d", i), {15'd0, bus.ready_d}, 16'd0);
            edge_wait();
            chk($sformatf("stall_hold_%0d", i), obs(), b_sw);
        end
        drive(1, rt(6'b100000), 0, 0);
        chk("unstall_ready", {15'd0, bus.ready_d}, 16'd1);
        edge_wait();
        chk("unstall_add", obs(), b_add);

        // Multiply interlock, continuous presentation
        drive(1, rt(6'b011000), 0, 0);
        edge_wait();                              // edge N
        chk("mul_bundle", obs(), b_mul);
        drive(1, rt(6'b100000), 0, 0);
        chk("mul_busy_ready_1", {15'd0, bus.ready_d}, 16'd0);
        edge_wait();                              // N+1
        chk("mul_bubble_1", obs(), B_NONE);
        chk("mul_busy_ready_2", {15'd0, bus.ready_d}, 16'd0);
        edge_wait();                              // N+2
        chk("mul_bubble_2", obs(), B_NONE);
        chk("mul_idle_ready", {15'd0, bus.ready_d}, 16'd1);
        edge_wait();                              // N+3
        chk("mul_then_add", obs(), b_add);

        // Multiply with 2 stalled cycles mid-busy: add accepted at N+5
        drive(1, rt(6'b011000), 0, 0);
        edge_wait();                              // N
        chk("mul2_bundle", obs(), b_mul);
        drive(1, rt(6'b100000), 0, 0);
        edge_wait();                              // N+1
        drive(1, rt(6'b100000), 1, 0);
        edge_wait();                              // N+2 stalled
        edge_wait();                              // N+3 stalled
        chk("mul2_stall_bubble", obs(), B_NONE);
        drive(1, rt(6'b100000), 0, 0);
        chk("mul2_still_busy", {15'd0, bus.ready_d}, 16'd0);
        edge_wait();                              // N+4
        chk("mul2_bubble_n4", obs(), B_NONE);
        chk("mul2_ready_n4", {15'd0, bus.ready_d}, 16'd1);
        edge_wait();                              // N+5
        chk("mul2_add_n5", obs(), b_add);

        // Flush with stall and valid together: bubble, instruction not consumed
        drive(1, rt(6'b100010), 1, 1);
        chk("flush_ready", {15'd0, bus.ready_d}, 16'd0);
        edge_wait();
        chk("flush_bubble", obs(), B_NONE);
        drive(1, rt(6'b100010), 0, 0);
        chk("flush_idle_ready", {15'd0, bus.ready_d}, 16'd1);
        edge_wait();
        chk("flush_represent_sub", obs(), b_sub);

        // Flush during MUL_BUSY aborts the interlock
        drive(1, rt(6'b011000), 0, 0);
        edge_wait();
        drive(1, rt(6'b100000), 0, 1);
        edge_wait();
        chk("mulflush_bubble", obs(), B_NONE);
        drive(1, rt(6'b100000), 0, 0);
        chk("mulflush_ready", {15'd0, bus.ready_d}, 16'd1);
        edge_wait();
        chk("mulflush_add", obs(), b_add);

        // Illegal opcode and illegal R-type funct
        drive(1, it(6'b111111), 0, 0);
        edge_wait();
        chk("illegal_opcode", obs(), B_ILL);
        drive(1, rt(6'b000001), 0, 0);
        edge_wait();
        chk("illegal_funct", obs(), B_ILL);

        // No valid instruction: bubble
        drive(0, it(6'b100011), 0, 0);
        edge_wait();
        chk("idle_bubble", obs(), B_NONE);

        // Asynchronous reset in the middle of MUL_BUSY
        drive(1, rt(6'b011000), 0, 0);
        edge_wait();
        chk("mulrst_bundle", obs(), b_mul);
        drive(1, it(6'b100011), 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mulrst_async_out", obs(), B_NONE);
        chk("mulrst_ready", {15'd0, bus.ready_d}, 16'd0);
        edge_wait();
        rst_n = 1'b1;
        #1;
        chk("mulrst_idle_ready", {15'd0, bus.ready_d}, 16'd1);
        edge_wait();
        chk("mulrst_lw", obs(), b_lw);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_pipe_unit.md
# control_pipe_unit

Registered, parametrised main decoder for the pipelined MIPS-subset core. It sits on the decode/execute boundary: it accepts one instruction per cycle from decode under a valid/ready handshake. It produces the complete execute-stage control bundle one cycle later and inserts bubbles for stall, flush and multi-cycle multiply. It supersedes the single-cycle decoder with explicit ALU codes, a jump/addi split, illegal-instruction flagging and a multiply busy interlock.

## Interface
- INSTR_W, 32, instruction width; opcode is bits [31:26], funct is bits [5:0]; must be ≥ 32
- ALU_CTRL_W, 4, ALU control width; the 4-bit codes are zero-extended; must be ≥ 4
- MUL_LATENCY, 3, execute cycles per multiply; must be ≥ 1
- clk  in  1  clock, all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_d  in  INSTR_W  instruction from decode
- valid_d  in  1  instr_d is valid
- ready_d  out  1  unit accepts instr_d this cycle (combinational)
- stall_e  in  1  execute stage cannot take a new bundle; hold outputs
- flush  in  1  kill the execute-stage bundle (branch taken / jump)
- valid_e  out  1  execute bundle is valid
- reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e, branch_e, jump_e  out  1 each  control bits
- alu_op_e  out  2  0 load/store/addi, 1 branch, 2 R-type, 3 jump
- alu_control_e  out  ALU_CTRL_W  ALU operation
- mul_e  out  1  bundle is a multiply
- illegal_e  out  1  opcode or funct not supported

## Operation
- Decode table (opcode → bits; unlisted bits are 0):
  - 000000 R-type: reg_write=1, reg_dst=1, alu_op=2; funct 100000 ADD=0010, 100010 SUB=0110, 100100 AND=0000, 100101 OR=0001, 101010 SLT=0111, 011000 MUL=1111 with mul=1
  - 100011 lw: reg_write=1, mem_to_reg=1, alu_src=1, alu_op=0, ADD
  - 101011 sw: mem_write=1, alu_src=1, alu_op=0, ADD
  - 001000 addi: reg_write=1, alu_src=1, alu_op=0, ADD
  - 000100 beq: branch=1, alu_op=1, SUB
  - 000010 j: jump=1, alu_op=3, alu_control=0
- Illegal opcode or illegal R-type funct: valid_e=1, illegal_e=1, all enables (reg_write, mem_write, branch, jump, mul) 0, alu_control=0.
- Bubble: valid_e=0 with all control outputs 0.
- FSM IDLE / MUL_BUSY; counter width $clog2(MUL_LATENCY+1).
  - IDLE: on accepted MUL with MUL_LATENCY>1, load count=MUL_LATENCY-1 and go to MUL_BUSY.
  - MUL_BUSY: decrement each cycle stall_e=0; on count reaching 1 with stall_e=0, go to IDLE; the execute register emits bubbles while busy.
- ready_d = rst_n & !stall_e & !flush & (state==IDLE).
- Priority per edge: reset > flush > stall_e > accept > bubble.
  - flush: load a bubble, force IDLE, clear count.
  - stall_e: hold all outputs and state.
  - accept (valid_d & ready_d): load the decoded bundle.
  - Otherwise: load a bubble.

## Timing
- Reset (async assert, sync use after deassert): every output 0 (valid_e=0, alu_op_e=0, alu_control_e=0, illegal_e=0); FSM IDLE; count 0. ready_d=0 while rst_n=0.
- Latency: instruction accepted at edge N → bundle valid after edge N; one instruction per cycle throughput in IDLE.
- Multiply: accepted at edge N; ready_d=0 for the next MUL_LATENCY-1 unstalled cycles; the next instruction is accepted at edge N+MUL_LATENCY earliest. Stalled cycles do not decrement.
- MUL_LATENCY=1: multiply behaves as single-cycle; no MUL_BUSY entry.
- flush asserted same cycle as valid_d: instruction not accepted (ready_d=0); decode must re-present it.
- flush during MUL_BUSY: abort interlock; ready_d returns to 1 the cycle after.
- Reset mid-MUL_BUSY: immediate return to IDLE, outputs 0.

## Test plan
- Reset: hold rst_n=0 with valid_d=1, instr_d=lw → all outputs 0, ready_d=0; release → first lw accepted, next cycle valid_e=1, mem_to_reg_e=1, alu_src_e=1, alu_control_e=0010.
- Back-to-back stream add, sub, and, or, slt, beq, j, addi, sw → one bundle per cycle with the listed codes (beq: branch_e=1, alu_op_e=1, 0110; j: jump_e=1, alu_op_e=3).
- MUL_LATENCY=3: mul then add presented continuously → mul_e bundle, then 2 bubbles, add accepted at edge N+3; repeat with stall_e=1 for 2 cycles mid-busy → add accepted at edge N+5.
- Stall: stall_e=1 for 3 cycles while sw is in execute → outputs hold sw bundle, ready_d=0; deassert → next instruction accepted.
- Flush with stall_e=1 and valid_d=1 simultaneously → next cycle bubble (valid_e=0), FSM IDLE, instruction not consumed.
- Illegal opcode 111111 and R-type funct 000001 → valid_e=1, illegal_e=1, reg_write_e=0, mem_write_e=0, alu_control_e=0.
